// File: rtl/multicycle_core_pkg.sv
// rtl/multicycle_core_pkg.sv - shared opcodes, FSM states and sizing helper for multicycle_core
package multicycle_core_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BR  = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    WB    = 2'd3
  } state_t;

  function automatic int instr_width(input int reg_aw);
    return 2 + 3 * reg_aw;
  endfunction

endpackage

// File: rtl/multicycle_core_regfile.sv
// rtl/multicycle_core_regfile.sv - 2**REG_AW x DATA_W register file, two async reads, one sync write
module core_regfile #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [2**REG_AW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle FETCH/EXEC/MEM/WB core with handshaked instruction and data memories
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REG_AW      = 2,
  parameter int PC_W        = 8,
  parameter int BRANCH_MODE = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          imem_req,
  output logic [PC_W-1:0]               imem_addr,
  input  logic                          imem_valid,
  input  logic [instr_width(REG_AW)-1:0] imem_data,
  output logic                          dmem_req,
  output logic                          dmem_we,
  output logic [DATA_W-1:0]             dmem_addr,
  output logic [DATA_W-1:0]             dmem_wdata,
  input  logic                          dmem_ack,
  input  logic [DATA_W-1:0]             dmem_rdata,
  output logic [PC_W-1:0]               pc,
  output logic                          wb_valid,
  output logic [REG_AW-1:0]             wb_reg,
  output logic [DATA_W-1:0]             wb_data
);

  localparam int IW = instr_width(REG_AW);

  state_t            state;
  logic [IW-1:0]     ir;
  logic [1:0]        op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rs_val, rt_val, imm_d, alu_sum, mem_addr;
  logic [PC_W-1:0]   imm_pc, pc_inc;
  logic              branch_taken;

  assign op = ir[IW-1 -: 2];
  assign rs = ir[3*REG_AW-1 -: REG_AW];
  assign rt = ir[2*REG_AW-1 -: REG_AW];
  assign rd = ir[REG_AW-1:0];

  assign imm_d    = DATA_W'($signed(rd));
  assign imm_pc   = PC_W'($signed(rd));
  assign alu_sum  = rs_val + rt_val;
  assign mem_addr = rs_val + imm_d;
  assign pc_inc   = pc + PC_W'(1);
  assign branch_taken = (BRANCH_MODE == 0) || (rs_val == rt_val);

  assign imem_addr = pc;

  // The write port is driven straight from the registered wb_* outputs during WB.
  core_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (state == WB),
    .waddr   (wb_reg),
    .wdata   (wb_data),
    .raddr_a (rs),
    .rdata_a (rs_val),
    .raddr_b (rt),
    .rdata_b (rt_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      ir         <= '0;
      pc         <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
    end else begin
      case (state)
        FETCH: begin
          // imem_req rises on the first clock after reset, so valid counts only once it is up
          if (imem_req && imem_valid) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= EXEC;
          end else begin
            imem_req <= 1'b1;
          end
        end
        EXEC: begin
          case (op)
            OP_ADD: begin
              wb_reg   <= rd;
              wb_data  <= alu_sum;
              wb_valid <= 1'b1;
              state    <= WB;
            end
            OP_LW, OP_SW: begin
              dmem_addr  <= mem_addr;
              dmem_wdata <= rt_val;
              dmem_we    <= (op == OP_SW);
              dmem_req   <= 1'b1;
              state      <= MEM;
            end
            OP_BR: begin
              pc       <= branch_taken ? pc_inc + imm_pc : pc_inc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              pc       <= pc_inc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end else begin
              wb_reg   <= rt;
              wb_data  <= dmem_rdata;
              wb_valid <= 1'b1;
              state    <= WB;
            end
          end
        end
        WB: begin
          wb_valid <= 1'b0;
          pc       <= pc_inc;
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - directed bench: two cores (branch modes 0 and 1) against behavioural ROM/RAM
module tb_multicycle_core;

  logic       clk = 1'b0;
  logic       reset;

  logic       imem_req0, imem_valid0, dmem_req0, dmem_we0, dmem_ack0, wb_valid0;
  logic [7:0] imem_addr0, imem_data0, dmem_addr0, dmem_wdata0, dmem_rdata0, pc0, wb_data0;
  logic [1:0] wb_reg0;

  logic       imem_req1, dmem_req1, dmem_we1, wb_valid1;
  logic [7:0] imem_addr1, imem_data1, dmem_addr1, dmem_wdata1, dmem_rdata1, pc1, wb_data1;
  logic [1:0] wb_reg1;

  logic [7:0] rom0 [256];
  logic [7:0] ram0 [256];
  logic [7:0] rom1 [256];
  logic [7:0] ram1 [256];

  int imem_wait, dmem_wait, icnt, dcnt, wb_cnt, wb_base;
  int n_pass, n_total;
  bit found;

  always #5 clk = ~clk;

  multicycle_core #(.DATA_W(8), .REG_AW(2), .PC_W(8), .BRANCH_MODE(0)) dut0 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req0), .imem_addr(imem_addr0), .imem_valid(imem_valid0), .imem_data(imem_data0),
    .dmem_req(dmem_req0), .dmem_we(dmem_we0), .dmem_addr(dmem_addr0), .dmem_wdata(dmem_wdata0),
    .dmem_ack(dmem_ack0), .dmem_rdata(dmem_rdata0),
    .pc(pc0), .wb_valid(wb_valid0), .wb_reg(wb_reg0), .wb_data(wb_data0)
  );

  // Second core sees valid/ack held high permanently, so stray handshakes must be ignored
  multicycle_core #(.DATA_W(8), .REG_AW(2), .PC_W(8), .BRANCH_MODE(1)) dut1 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_valid(1'b1), .imem_data(imem_data1),
    .dmem_req(dmem_req1), .dmem_we(dmem_we1), .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
    .dmem_ack(1'b1), .dmem_rdata(dmem_rdata1),
    .pc(pc1), .wb_valid(wb_valid1), .wb_reg(wb_reg1), .wb_data(wb_data1)
  );

  assign imem_data0  = rom0[imem_addr0];
  assign dmem_rdata0 = ram0[dmem_addr0];
  assign imem_data1  = rom1[imem_addr1];
  assign dmem_rdata1 = ram1[dmem_addr1];
  assign imem_valid0 = imem_req0 && (icnt >= imem_wait);
  assign dmem_ack0   = dmem_req0 && (dcnt >= dmem_wait);

  always @(posedge clk) begin
    icnt <= (imem_req0 && !imem_valid0) ? icnt + 1 : 0;
    dcnt <= (dmem_req0 && !dmem_ack0) ? dcnt + 1 : 0;
    if (wb_valid0) wb_cnt <= wb_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_total = 0; icnt = 0; dcnt = 0; wb_cnt = 0;
    imem_wait = 0; dmem_wait = 0; reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom0[i] = 8'h00; rom1[i] = 8'h00; ram0[i] = 8'h00; ram1[i] = 8'h00;
    end
    rom0[0] = 8'h47; rom0[1] = 8'h16; rom0[2] = 8'h99; rom0[5] = 8'hC3;
    rom1[0] = 8'h47; rom1[1] = 8'h16; rom1[2] = 8'h99; rom1[5] = 8'hC7; rom1[6] = 8'hC3;
    ram0[8'hFF] = 8'h05; ram1[8'hFF] = 8'h05;

    step(2);
    check("rst_pc", pc0, 8'h00);
    check("rst_imem_req", imem_req0, 1'b0);
    check("rst_dmem_req", dmem_req0, 1'b0);
    check("rst_dmem_we", dmem_we0, 1'b0);
    check("rst_wb_valid", wb_valid0, 1'b0);
    check("rst_wb_data", wb_data0, 8'h00);
    check("rst_dmem_addr", dmem_addr0, 8'h00);
    reset = 1'b1;

    step(1);
    check("f0_imem_req", imem_req0, 1'b1);
    check("f0_imem_addr", imem_addr0, 8'h00);
    step(2);
    check("lw_dmem_req", dmem_req0, 1'b1);
    check("lw_dmem_addr", dmem_addr0, 8'hFF);
    check("lw_dmem_we", dmem_we0, 1'b0);
    step(1);
    check("lw_wb_valid", wb_valid0, 1'b1);
    check("lw_wb_reg", wb_reg0, 2'd1);
    check("lw_wb_data", wb_data0, 8'h05);
    step(1);
    check("lw_pc", pc0, 8'h01);
    check("lw_wb_drop", wb_valid0, 1'b0);
    step(2);
    check("add_wb_valid", wb_valid0, 1'b1);
    check("add_wb_reg", wb_reg0, 2'd2);
    check("add_wb_data", wb_data0, 8'h0A);
    step(1);
    check("add_pc", pc0, 8'h02);
    step(2);
    check("sw_dmem_req", dmem_req0, 1'b1);
    check("sw_dmem_we", dmem_we0, 1'b1);
    check("sw_dmem_addr", dmem_addr0, 8'h06);
    check("sw_dmem_wdata", dmem_wdata0, 8'h0A);
    check("sw_no_wb", wb_valid0, 1'b0);
    step(1);
    check("sw_pc", pc0, 8'h03);
    check("sw_req_drop", dmem_req0, 1'b0);
    check("sw_no_wb2", wb_valid0, 1'b0);
    step(6);
    check("pre_br_pc0", pc0, 8'h05);
    check("pre_br_pc1", pc1, 8'h05);
    step(2);
    check("br0_pc", pc0, 8'h05);
    check("br0_refetch", imem_req0, 1'b1);
    check("br1_not_taken_pc", pc1, 8'h06);
    step(10);
    check("br0_loop_pc", pc0, 8'h05);
    check("br1_loop_pc", pc1, 8'h06);

    // Stalled LW then stalled fetch
    reset = 1'b0;
    rom0[0] = 8'h47; rom0[1] = 8'h47; dmem_wait = 3;
    step(1);
    reset = 1'b1;
    step(2);
    wb_base = wb_cnt;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("stall_dmem_req%0d", i), dmem_req0, 1'b1);
      check($sformatf("stall_dmem_addr%0d", i), dmem_addr0, 8'hFF);
    end
    step(1);
    check("stall_wb_data", wb_data0, 8'h05);
    imem_wait = 2;
    step(1);
    check("stall_single_wb", wb_cnt - wb_base, 1);
    check("stall_pc", pc0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fwait_imem_addr%0d", i), imem_addr0, 8'h01);
      check($sformatf("fwait_imem_req%0d", i), imem_req0, 1'b1);
      if (i < 2) step(1);
    end
    step(1);
    check("fwait_exec", imem_req0, 1'b0);
    imem_wait = 0; dmem_wait = 10;

    // Reset in the middle of a long MEM stall
    step(3);
    check("mid_dmem_req", dmem_req0, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_dmem_req", dmem_req0, 1'b0);
    check("abort_pc", pc0, 8'h00);
    check("abort_wb_valid", wb_valid0, 1'b0);
    rom0[0] = 8'h16; rom0[1] = 8'h47; rom0[2] = 8'h48;
    for (int i = 3; i < 255; i++) rom0[i] = 8'h00;
    rom0[255] = 8'h1B;
    ram0[8'hFF] = 8'hFF; ram0[8'h00] = 8'h01;
    dmem_wait = 0;
    step(1);
    reset = 1'b1;
    step(1);
    check("restart_imem_addr", imem_addr0, 8'h00);
    check("restart_imem_req", imem_req0, 1'b1);
    step(2);
    check("cleared_wb_valid", wb_valid0, 1'b1);
    check("cleared_wb_data", wb_data0, 8'h00);

    // Run NOP ADDs up to pc=0xFF, then ADD r3 = 0xFF + 0x01
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step(1);
      if (wb_valid0 && wb_reg0 == 2'd3) found = 1'b1;
    end
    check("wrap_reached", found, 1'b1);
    check("wrap_add_pc", pc0, 8'hFF);
    check("wrap_add_data", wb_data0, 8'h00);
    step(1);
    check("wrap_pc", pc0, 8'h00);
    check("wrap_imem_addr", imem_addr0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
